// File: rtl/adder_measure_sequencer_pkg.sv
// adder_measure_sequencer_pkg: shared state encoding and default widths for the measurement sequencer
package adder_measure_sequencer_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_SETTLE = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;

endpackage

// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer: drives one instrumented-adder measurement per host command and returns sum and ring count
module adder_measure_sequencer
    import adder_measure_sequencer_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_cycles,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic [CNT_W-1:0] rsp_count,
    output logic [WIDTH-1:0] adder_a,
    output logic [WIDTH-1:0] adder_b,
    output logic             adder_cnt_clr,
    output logic             adder_run,
    input  logic [WIDTH-1:0] adder_sum,
    input  logic [CNT_W-1:0] adder_count
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    logic [2:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             accept, sample;

    assign accept = (state == ST_IDLE) && cmd_valid;
    assign sample = (state == ST_SETTLE) && (cnt == CNT_ONE);

    // Next state; one down-counter serves the run window and then the settle wait.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                state_nx = cmd_valid ? ST_LOAD : ST_IDLE;
                cnt_nx   = cmd_valid ? cmd_cycles : cnt;
            end
            ST_LOAD: begin
                state_nx = (cnt != '0) ? ST_RUN : ST_SETTLE;
                cnt_nx   = (cnt != '0) ? cnt : SETTLE_CNT;
            end
            ST_RUN: begin
                state_nx = (cnt == CNT_ONE) ? ST_SETTLE : ST_RUN;
                cnt_nx   = (cnt == CNT_ONE) ? SETTLE_CNT : cnt - CNT_ONE;
            end
            ST_SETTLE: begin
                state_nx = (cnt == CNT_ONE) ? ST_RESP : ST_SETTLE;
                cnt_nx   = cnt - CNT_ONE;
            end
            ST_RESP: state_nx = rsp_ready ? ST_IDLE : ST_RESP;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State, counter and every output are registered; control outputs decode the next state so they align with it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            adder_run     <= 1'b0;
            adder_cnt_clr <= 1'b0;
            adder_a       <= '0;
            adder_b       <= '0;
            rsp_sum       <= '0;
            rsp_count     <= '0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            cmd_ready     <= state_nx == ST_IDLE;
            rsp_valid     <= state_nx == ST_RESP;
            adder_run     <= state_nx == ST_RUN;
            adder_cnt_clr <= state_nx == ST_LOAD;
            if (accept) begin
                adder_a <= cmd_a;
                adder_b <= cmd_b;
            end
            if (sample) begin
                rsp_sum   <= adder_sum;
                rsp_count <= adder_count;
            end
        end
    end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// tb_adder_measure_sequencer: scoreboard bench with a stub instrumented adder
module tb_adder_measure_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [31:0] cmd_a = '0, cmd_b = '0, cmd_cycles = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_sum, rsp_count;
    logic [31:0] adder_a, adder_b, adder_sum, adder_count;
    logic        adder_cnt_clr, adder_run;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int run_hi = 0;
    int clr_hi = 0;
    logic [63:0] q[$];
    logic [63:0] got[$];

    always #5 clk = ~clk;

    adder_measure_sequencer #(.WIDTH(32), .CNT_W(32), .SETTLE(2)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cycles(cmd_cycles),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_count(rsp_count),
        .adder_a(adder_a), .adder_b(adder_b),
        .adder_cnt_clr(adder_cnt_clr), .adder_run(adder_run),
        .adder_sum(adder_sum), .adder_count(adder_count)
    );

    // Stub adder: registered sum, ring counter that counts while run and clears on clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_sum   <= '0;
            adder_count <= '0;
        end else begin
            adder_sum   <= adder_a + adder_b;
            adder_count <= adder_cnt_clr ? '0 : adder_run ? adder_count + 32'd1 : adder_count;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (adder_run) run_hi <= run_hi + 1;
        if (adder_cnt_clr) clr_hi <= clr_hi + 1;
        if (rsp_valid && rsp_ready) got.push_back({rsp_sum, rsp_count});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                        input bit keep, output int t);
        int i;
        @(negedge clk);
        cmd_a = a; cmd_b = b; cmd_cycles = n; cmd_valid = 1'b1;
        i = 0;
        while (!cmd_ready && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!cmd_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        t = cyc;
        q.push_back({a + b, n});
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic await_rsp(output int t);
        int i;
        i = 0;
        while (!rsp_valid && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (!rsp_valid) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
        end
        t = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({cmd_ready, rsp_valid, adder_run, adder_cnt_clr} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctrl: got ready/valid/run/clr=%b required 1000",
                     {cmd_ready, rsp_valid, adder_run, adder_cnt_clr});
        end
        tests++;
        if ({adder_a, adder_b} !== 64'd0) begin
            fails++;
            $display("FAIL reset_operands: got a=%h b=%h required 0 0", adder_a, adder_b);
        end
        tests++;
        if ({rsp_sum, rsp_count} !== 64'd0) begin
            fails++;
            $display("FAIL reset_rsp: got sum=%h count=%h required 0 0", rsp_sum, rsp_count);
        end
    endtask

    task automatic test_basic();
        int t, tr, r0, c0;
        logic [63:0] exp;
        r0 = run_hi; c0 = clr_hi;
        send(32'd5, 32'd7, 32'd10, 1'b0, t);
        await_rsp(tr);
        tests++;
        if (tr - t !== 13) begin
            fails++;
            $display("FAIL basic_latency: rsp_valid set %0d edges after accept, required 13", tr - t);
        end
        tests++;
        if (run_hi - r0 !== 10) begin
            fails++;
            $display("FAIL basic_run_len: adder_run high %0d cycles, required 10", run_hi - r0);
        end
        tests++;
        if (clr_hi - c0 !== 1) begin
            fails++;
            $display("FAIL basic_clr: clr pulses %0d, required 1", clr_hi - c0);
        end
        exp = q.pop_front();
        tests++;
        if ({rsp_sum, rsp_count} !== exp || rsp_sum !== 32'd12 || rsp_count !== 32'd10) begin
            fails++;
            $display("FAIL basic_data: got sum=%0d count=%0d required sum=%0d count=%0d",
                     rsp_sum, rsp_count, exp[63:32], exp[31:0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_release: got valid=%0b ready=%0b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_zero_cycles();
        int t, tr, r0;
        logic [63:0] exp;
        r0 = run_hi;
        send(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, t);
        await_rsp(tr);
        tests++;
        if (tr - t !== 3) begin
            fails++;
            $display("FAIL zero_latency: rsp_valid set %0d edges after accept, required 3", tr - t);
        end
        tests++;
        if (run_hi - r0 !== 0) begin
            fails++;
            $display("FAIL zero_run: adder_run high %0d cycles, required 0", run_hi - r0);
        end
        exp = q.pop_front();
        tests++;
        if ({rsp_sum, rsp_count} !== exp || {rsp_sum, rsp_count} !== 64'd0) begin
            fails++;
            $display("FAIL zero_data: got sum=%h count=%h required sum=%h count=%h",
                     rsp_sum, rsp_count, exp[63:32], exp[31:0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        int t, tr, bad;
        logic [63:0] exp;
        send(32'd3, 32'd4, 32'd2, 1'b0, t);
        await_rsp(tr);
        exp = q.pop_front();
        cmd_a = 32'd100; cmd_b = 32'd200; cmd_cycles = 32'd1; cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || {rsp_sum, rsp_count} !== exp || adder_a !== 32'd3)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL hold_stable: %0d unstable cycles (valid=%0b ready=%0b sum=%0d cnt=%0d a=%0d), required 0",
                     bad, rsp_valid, cmd_ready, rsp_sum, rsp_count, adder_a);
        end
        tests++;
        if (rsp_sum !== 32'd7 || rsp_count !== 32'd2) begin
            fails++;
            $display("FAIL hold_data: got sum=%0d count=%0d required 7 2", rsp_sum, rsp_count);
        end
        q.push_back({32'd300, 32'd1});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tests++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || adder_a !== 32'd3) begin
            fails++;
            $display("FAIL hold_after_take: got ready=%0b valid=%0b a=%0d required 1 0 3",
                     cmd_ready, rsp_valid, adder_a);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests++;
        if (cmd_ready !== 1'b0 || adder_a !== 32'd100 || adder_b !== 32'd200) begin
            fails++;
            $display("FAIL hold_second_accept: got ready=%0b a=%0d b=%0d required 0 100 200",
                     cmd_ready, adder_a, adder_b);
        end
        await_rsp(tr);
        exp = q.pop_front();
        tests++;
        if ({rsp_sum, rsp_count} !== exp) begin
            fails++;
            $display("FAIL hold_second_data: got sum=%0d count=%0d required sum=%0d count=%0d",
                     rsp_sum, rsp_count, exp[63:32], exp[31:0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int t, seen, i, bad;
        logic [63:0] dropped;
        send(32'd1, 32'd2, 32'd10, 1'b0, t);
        dropped = q.pop_back();
        seen = 0; i = 0;
        while (seen < 3 && i < 50) begin
            @(negedge clk);
            if (adder_run) seen++;
            i++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (adder_run !== 1'b0 || seen !== 3) begin
            fails++;
            $display("FAIL midrun_reset: got run=%0b after %0d run cycles (payload %h), required 0 after 3",
                     adder_run, seen, dropped);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid || adder_run) bad++;
        end
        rsp_ready = 1'b0;
        tests++;
        if (bad !== 0 || cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrun_idle: %0d cycles with valid/run, ready=%0b, required 0 and 1", bad, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2, i, r0, c0;
        logic [63:0] e0, e1;
        got.delete();
        rsp_ready = 1'b1;
        r0 = run_hi; c0 = clr_hi;
        send(32'd10, 32'd20, 32'd3, 1'b1, t1);
        cmd_a = 32'd1; cmd_b = 32'd1; cmd_cycles = 32'd4;
        i = 0;
        while (!cmd_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        @(negedge clk);
        t2 = cyc;
        cmd_valid = 1'b0;
        q.push_back({32'd2, 32'd4});
        tests++;
        if (t2 - t1 !== 8) begin
            fails++;
            $display("FAIL b2b_spacing: accepts %0d edges apart, required 8", t2 - t1);
        end
        i = 0;
        while (got.size() < 2 && i < 100) begin
            @(negedge clk);
            i++;
        end
        rsp_ready = 1'b0;
        tests++;
        if (got.size() !== 2) begin
            fails++;
            $display("FAIL b2b_count: got %0d responses, required 2", got.size());
        end else begin
            e0 = q.pop_front();
            e1 = q.pop_front();
            tests++;
            if (got[0] !== e0 || got[0][31:0] !== 32'd3) begin
                fails++;
                $display("FAIL b2b_first: got %h required %h", got[0], e0);
            end
            tests++;
            if (got[1] !== e1 || got[1][31:0] !== 32'd4) begin
                fails++;
                $display("FAIL b2b_second: got %h required %h", got[1], e1);
            end
        end
        tests++;
        if (clr_hi - c0 !== 2 || run_hi - r0 !== 7) begin
            fails++;
            $display("FAIL b2b_pulses: clr=%0d run=%0d required 2 7", clr_hi - c0, run_hi - r0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_cycles();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
